// File: rtl/glyph_fetch_scheduler.sv
// glyph_fetch_scheduler: text-overlay front end; shares the char buffer with a writer and fetches glyph rows one cell ahead of the beam
// Ports: clk/reset (sync, active-high); p_tick, X, Y, video_on from sync; R,G,B colour switches;
//   wr_req/wr_addr/wr_data/wr_ack writer handshake; mem_addr/mem_we/mem_wdata/mem_rdata buffer port;
//   rom_code/rom_row/rom_data glyph ROM; cur_addr cursor cell; L pixel colour.
// Optional macro GLYPH_CURSOR_EN adds a blinking inverted cursor at cur_addr.
module glyph_fetch_scheduler #(
  parameter int COLS = 10,
  parameter int ROWS = 4,
  parameter int X0 = 64,
  parameter int Y0 = 0,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_tick,
  input  logic [9:0]    X,
  input  logic [9:0]    Y,
  input  logic          video_on,
  input  logic          R,
  input  logic          G,
  input  logic          B,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    rom_code,
  output logic [3:0]    rom_row,
  input  logic [7:0]    rom_data,
  input  logic [AW-1:0] cur_addr,
  output logic [2:0]    L
);
  typedef enum logic [1:0] {IDLE, ISSUE, CODE, GLYPH} state_t;
  localparam logic [9:0] XL = 10'(X0);
  localparam logic [9:0] XT = 10'(X0 - 8);
  localparam logic [9:0] YL = 10'(Y0);
  localparam logic [9:0] XSPAN = 10'(8 * COLS);
  localparam logic [9:0] YSPAN = 10'(16 * ROWS);
  state_t state_q;
  logic [3:0] row_q;
  logic [7:0] glyph_cur_q, glyph_next_q;
  logic next_valid_q;
  logic y_in, in_win, cell_edge, trig, swap, bit_v, inv, pix;
  logic [6:0] ncol;
  logic [5:0] nline;
  logic [AW-1:0] tgt_addr;
  // Unsigned wrap makes a single compare cover both window bounds
  assign y_in = (Y - YL) < YSPAN;
  assign in_win = y_in && ((X - XL) < XSPAN);
  assign cell_edge = X[2:0] == 3'd0;
  assign swap = p_tick && cell_edge;
  // Trigger looks one cell ahead: X+8 must land in the window
  assign trig = swap && y_in && ((X - XT) < XSPAN);
  assign ncol = 7'((X - XT) >> 3);
  assign nline = 6'((Y - YL) >> 4);
  assign tgt_addr = AW'(nline) * AW'(COLS) + AW'(ncol);
  // First pixel of a cell comes straight from the freshly fetched row
  assign bit_v = cell_edge ? glyph_next_q[0] : glyph_cur_q[X[2:0]];
  assign pix = (bit_v ^ inv) & in_win & video_on;
`ifdef GLYPH_CURSOR_EN
  logic [4:0] frame_q;
  logic [6:0] pcol;
  logic [AW-1:0] pix_addr;
  assign pcol = 7'((X - XL) >> 3);
  assign pix_addr = AW'(nline) * AW'(COLS) + AW'(pcol);
  assign inv = frame_q[4] && pix_addr == cur_addr;
  always_ff @(posedge clk)
    if (reset) frame_q <= '0;
    else if (p_tick && X == 10'd0 && Y == 10'd0) frame_q <= frame_q + 5'd1;
`else
  logic unused_cur;
  assign unused_cur = ^cur_addr;
  assign inv = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q <= '0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      wr_ack <= 1'b0;
      rom_code <= '0;
      rom_row <= '0;
      glyph_cur_q <= '0;
      glyph_next_q <= '0;
      next_valid_q <= 1'b0;
      L <= '0;
    end else begin
      mem_we <= 1'b0;
      wr_ack <= 1'b0;
      // Display read has priority; a writer is granted only when ack is low
      if (state_q == IDLE && trig) begin
        state_q <= ISSUE;
        mem_addr <= tgt_addr;
        row_q <= 4'(Y - YL);
      end else if (wr_req && !wr_ack) begin
        mem_addr <= wr_addr;
        mem_wdata <= wr_data;
        mem_we <= 1'b1;
        wr_ack <= 1'b1;
      end
      if (state_q == ISSUE) state_q <= CODE;
      if (state_q == CODE) begin
        state_q <= GLYPH;
        rom_code <= mem_rdata;
        rom_row <= row_q;
      end
      if (state_q == GLYPH) begin
        state_q <= IDLE;
        glyph_next_q <= rom_data;
      end
      if (swap) glyph_cur_q <= next_valid_q ? glyph_next_q : '0;
      next_valid_q <= state_q == GLYPH || (next_valid_q && !swap);
      if (p_tick) L <= pix ? {R, G, B} : 3'b000;
    end
  end
endmodule
